// File: rtl/pacman_pkg.sv
// Shared types, grid constants and small helpers for the Pac-Man game blocks.
// Coordinates are column (x, 0..39) and row (y, 0..29).
package pacman_pkg;

   localparam logic [3:0] CELL_EMPTY      = 4'd0;
   localparam logic [3:0] CELL_DOT        = 4'd1;
   localparam logic [3:0] CELL_PILL       = 4'd2;
   localparam logic [3:0] CELL_WALL       = 4'd3;
   localparam logic [3:0] CELL_PACMAN     = 4'd4;
   localparam logic [3:0] CELL_GHOST      = 4'd5;
   localparam logic [3:0] CELL_GHOST_DOT  = 4'd6;
   localparam logic [3:0] CELL_GHOST_PILL = 4'd7;

   localparam int MAP_W = 40;
   localparam int MAP_H = 30;

   typedef logic [5:0] xcoord_t;
   typedef logic [4:0] ycoord_t;
   typedef logic [6:0] dist_t;

   typedef struct packed {
      xcoord_t x;
      ycoord_t y;
   } cell_t;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECIDE = 2'd1,
      ST_WAIT   = 2'd2
   } ghost_state_t;

   localparam xcoord_t X_COUNT = xcoord_t'(MAP_W);
   localparam ycoord_t Y_COUNT = ycoord_t'(MAP_H);
   localparam xcoord_t X_LAST  = xcoord_t'(MAP_W - 1);
   localparam ycoord_t Y_LAST  = ycoord_t'(MAP_H - 1);

   function automatic logic inGrid(input cell_t c);
      return (c.x < X_COUNT) && (c.y < Y_COUNT);
   endfunction

   // Stepping off column/row 0 wraps to 63/31, which inGrid rejects.
   function automatic cell_t stepCell(input cell_t c, input logic [1:0] dir);
      cell_t n;
      n = c;
      case (dir)
         DIR_UP:   n.y = c.y - 5'd1;
         DIR_DOWN: n.y = c.y + 5'd1;
         DIR_LEFT: n.x = c.x - 6'd1;
         default:  n.x = c.x + 6'd1;
      endcase
      return n;
   endfunction

   function automatic dist_t manhattan(input cell_t a, input cell_t b);
      xcoord_t dx;
      ycoord_t dy;
      dx = (a.x >= b.x) ? (a.x - b.x) : (b.x - a.x);
      dy = (a.y >= b.y) ? (a.y - b.y) : (b.y - a.y);
      return {1'b0, dx} + {2'b00, dy};
   endfunction

   // Strict comparison means the earliest candidate in 'order' wins a tie.
   function automatic cell_t pickCell(input cell_t [3:0]       cand,
                                      input logic  [3:0]       legal,
                                      input logic  [3:0][1:0]  order,
                                      input cell_t             target,
                                      input logic              maximise,
                                      input cell_t             stay);
      cell_t      best;
      dist_t      bestDist;
      dist_t      d;
      logic       found;
      logic [1:0] idx;
      best     = stay;
      bestDist = '0;
      found    = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = order[k];
         d   = manhattan(cand[idx], target);
         if (legal[idx] && (!found || (maximise ? (d > bestDist) : (d < bestDist)))) begin
            best     = cand[idx];
            bestDist = d;
            found    = 1'b1;
         end
      end
      return best;
   endfunction

endpackage

// File: rtl/ghost_wall_rom.sv
// Combinational wall bitmap of the maze with two independent read ports.
// The layout mirrors the wall cells of the map RAM; anything off the grid reads as wall.
module ghost_wall_rom
   import pacman_pkg::*;
(
   input  logic [5:0] rdAx_i,
   input  logic [4:0] rdAy_i,
   input  logic [5:0] rdBx_i,
   input  logic [4:0] rdBy_i,
   output logic       wallA_o,
   output logic       wallB_o
);

   localparam cell_t BOX_A = '{x: 6'd5,  y: 5'd5};
   localparam cell_t BOX_B = '{x: 6'd10, y: 5'd5};

   function automatic logic ringOf(input cell_t c, input cell_t centre);
      return ((c.x == centre.x) && ((c.y == centre.y - 5'd1) || (c.y == centre.y + 5'd1))) ||
             ((c.y == centre.y) && ((c.x == centre.x - 6'd1) || (c.x == centre.x + 6'd1)));
   endfunction

   // Outer border plus two enclosed pockets in the upper-left area of the maze.
   function automatic logic wallAt(input cell_t c);
      if (!inGrid(c)) begin
         return 1'b1;
      end
      if ((c.x == '0) || (c.x == X_LAST) || (c.y == '0) || (c.y == Y_LAST)) begin
         return 1'b1;
      end
      return ringOf(c, BOX_A) || ringOf(c, BOX_B);
   endfunction

   assign wallA_o = wallAt(cell_t'({rdAx_i, rdAy_i}));
   assign wallB_o = wallAt(cell_t'({rdBx_i, rdBy_i}));

endmodule

// File: rtl/ghost_loc_ctrl.sv
// Two-ghost location controller: periodically picks each ghost's next cell and
// commits it once the map-RAM writer reports both ghosts rewritten.
module ghost_loc_ctrl
   import pacman_pkg::*;
#(
   parameter int MOVE_PERIOD = 2_500_000,
   parameter int G1_X0       = 19,
   parameter int G1_Y0       = 14,
   parameter int G2_X0       = 20,
   parameter int G2_Y0       = 14
)(
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic [5:0]  curr_pacman_x,
   input  logic [4:0]  curr_pacman_y,
   input  logic [3:0]  collision_type,
   input  logic [32:0] pill_counter,
   input  logic        wrdone,
   output logic [5:0]  curr_ghost1_x,
   output logic [4:0]  curr_ghost1_y,
   output logic [5:0]  curr_ghost2_x,
   output logic [4:0]  curr_ghost2_y,
   output logic [5:0]  next_ghost1_x,
   output logic [4:0]  next_ghost1_y,
   output logic [5:0]  next_ghost2_x,
   output logic [4:0]  next_ghost2_y
);

   localparam int               CNT_W    = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_PERIOD - 1);

   localparam cell_t G1_HOME = '{x: xcoord_t'(G1_X0), y: ycoord_t'(G1_Y0)};
   localparam cell_t G2_HOME = '{x: xcoord_t'(G2_X0), y: ycoord_t'(G2_Y0)};

   // Rank k holds the direction tried k-th: ghost1 up/down/left/right, ghost2 left/right/up/down.
   localparam logic [3:0][1:0] G1_ORDER = {DIR_RIGHT, DIR_LEFT, DIR_DOWN, DIR_UP};
   localparam logic [3:0][1:0] G2_ORDER = {DIR_DOWN, DIR_UP, DIR_RIGHT, DIR_LEFT};

   ghost_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   cell_t            g1Curr_q, g1Curr_d;
   cell_t            g2Curr_q, g2Curr_d;
   cell_t            g1Next_q, g1Next_d;
   cell_t            g2Next_q, g2Next_d;

   cell_t [3:0] g1Cand;
   cell_t [3:0] g2Cand;
   logic  [3:0] g1Wall;
   logic  [3:0] g2Wall;
   logic  [3:0] g1Legal;
   logic  [3:0] g2Legal;
   cell_t       g1Pick;
   cell_t       g2Pick;
   cell_t       pacCell;
   logic        frightened;
   logic        caught;

   assign pacCell    = '{x: curr_pacman_x, y: curr_pacman_y};
   assign frightened = |pill_counter;
   assign caught     = collision_type inside {CELL_GHOST, CELL_GHOST_DOT, CELL_GHOST_PILL};

   always_comb begin
      for (int d = 0; d < 4; d++) begin
         g1Cand[d] = stepCell(g1Curr_q, 2'(d));
         g2Cand[d] = stepCell(g2Curr_q, 2'(d));
      end
   end

   // One ROM per direction: port A serves ghost1's candidate, port B ghost2's.
   for (genvar d = 0; d < 4; d++) begin : genRom
      ghost_wall_rom uRom (
         .rdAx_i  (g1Cand[d].x),
         .rdAy_i  (g1Cand[d].y),
         .rdBx_i  (g2Cand[d].x),
         .rdBy_i  (g2Cand[d].y),
         .wallA_o (g1Wall[d]),
         .wallB_o (g2Wall[d])
      );
   end

   // Ghost1 avoids ghost2's pending target; ghost2 then avoids ghost1's fresh choice.
   always_comb begin
      for (int d = 0; d < 4; d++) begin
         g1Legal[d] = !g1Wall[d] && inGrid(g1Cand[d]) && (g1Cand[d] != g2Next_q);
      end
      g1Pick = pickCell(g1Cand, g1Legal, G1_ORDER, pacCell, frightened, g1Curr_q);
      for (int d = 0; d < 4; d++) begin
         g2Legal[d] = !g2Wall[d] && inGrid(g2Cand[d]) && (g2Cand[d] != g1Pick);
      end
      g2Pick = pickCell(g2Cand, g2Legal, G2_ORDER, pacCell, frightened, g2Curr_q);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      g1Curr_d = g1Curr_q;
      g2Curr_d = g2Curr_q;
      g1Next_d = g1Next_q;
      g2Next_d = g2Next_q;
      case (state_q)
         ST_IDLE: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_DECIDE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DECIDE: begin
            if (caught) begin
               g1Next_d = g1Curr_q;
               g2Next_d = g2Curr_q;
            end else begin
               g1Next_d = g1Pick;
               g2Next_d = g2Pick;
            end
            // With nothing to redraw the writer never answers, so do not wait for it.
            if ((g1Next_d == g1Curr_q) && (g2Next_d == g2Curr_q)) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (wrdone) begin
               g1Curr_d = g1Next_q;
               g2Curr_d = g2Next_q;
               cnt_d    = '0;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         g1Curr_q <= G1_HOME;
         g2Curr_q <= G2_HOME;
         g1Next_q <= G1_HOME;
         g2Next_q <= G2_HOME;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         g1Curr_q <= g1Curr_d;
         g2Curr_q <= g2Curr_d;
         g1Next_q <= g1Next_d;
         g2Next_q <= g2Next_d;
      end
   end

   assign curr_ghost1_x = g1Curr_q.x;
   assign curr_ghost1_y = g1Curr_q.y;
   assign curr_ghost2_x = g2Curr_q.x;
   assign curr_ghost2_y = g2Curr_q.y;
   assign next_ghost1_x = g1Next_q.x;
   assign next_ghost1_y = g1Next_q.y;
   assign next_ghost2_x = g2Next_q.x;
   assign next_ghost2_y = g2Next_q.y;

endmodule

// File: tb/tb_ghost_loc_ctrl.sv
// Scoreboard bench for ghost_loc_ctrl: one DUT in the open maze, one with both ghosts
// walled in; the monitor compares every output change or probe against the queue.
module tb_ghost_loc_ctrl;

   logic        clk;
   logic        reset;
   logic [5:0]  pacX;
   logic [4:0]  pacY;
   logic [3:0]  collisionType;
   logic [32:0] pillCounter;
   logic        wrdone;
   logic        probeReq;

   logic [5:0] mCg1x, mCg2x, mNg1x, mNg2x;
   logic [4:0] mCg1y, mCg2y, mNg1y, mNg2y;
   logic [5:0] bCg1x, bCg2x, bNg1x, bNg2x;
   logic [4:0] bCg1y, bCg2y, bNg1y, bNg2y;
   logic [87:0] observed;

   typedef struct {
      string       name;
      logic [87:0] value;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   ghost_loc_ctrl #(.MOVE_PERIOD(4)) dutMain (
      .CLOCK_50       (clk),
      .reset          (reset),
      .curr_pacman_x  (pacX),
      .curr_pacman_y  (pacY),
      .collision_type (collisionType),
      .pill_counter   (pillCounter),
      .wrdone         (wrdone),
      .curr_ghost1_x  (mCg1x),
      .curr_ghost1_y  (mCg1y),
      .curr_ghost2_x  (mCg2x),
      .curr_ghost2_y  (mCg2y),
      .next_ghost1_x  (mNg1x),
      .next_ghost1_y  (mNg1y),
      .next_ghost2_x  (mNg2x),
      .next_ghost2_y  (mNg2y)
   );

   ghost_loc_ctrl #(.MOVE_PERIOD(4), .G1_X0(5), .G1_Y0(5), .G2_X0(10), .G2_Y0(5)) dutBox (
      .CLOCK_50       (clk),
      .reset          (reset),
      .curr_pacman_x  (pacX),
      .curr_pacman_y  (pacY),
      .collision_type (collisionType),
      .pill_counter   (pillCounter),
      .wrdone         (wrdone),
      .curr_ghost1_x  (bCg1x),
      .curr_ghost1_y  (bCg1y),
      .curr_ghost2_x  (bCg2x),
      .curr_ghost2_y  (bCg2y),
      .next_ghost1_x  (bNg1x),
      .next_ghost1_y  (bNg1y),
      .next_ghost2_x  (bNg2x),
      .next_ghost2_y  (bNg2y)
   );

   assign observed = {mCg1x, mCg1y, mCg2x, mCg2y, mNg1x, mNg1y, mNg2x, mNg2y,
                      bCg1x, bCg1y, bCg2x, bCg2y, bNg1x, bNg1y, bNg2x, bNg2y};

   // Bundle order: curr1, curr2, next1, next2 as (x,y) pairs.
   function automatic logic [43:0] cells(input int c1x, input int c1y, input int c2x, input int c2y,
                                         input int n1x, input int n1y, input int n2x, input int n2y);
      return {6'(c1x), 5'(c1y), 6'(c2x), 5'(c2y), 6'(n1x), 5'(n1y), 6'(n2x), 5'(n2y)};
   endfunction

   // The walled-in ghosts can never leave their home cells.
   task automatic pushExp(input string name, input logic [43:0] mainExp);
      exp_t e;
      e.name  = name;
      e.value = {mainExp, cells(5, 5, 10, 5, 5, 5, 10, 5)};
      expQ.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic probe(input string name, input logic [43:0] mainExp);
      pushExp(name, mainExp);
      probeReq = 1'b1;
      tick(1);
      probeReq = 1'b0;
   endtask

   task automatic checkOutput(input logic [87:0] got);
      exp_t e;
      checks++;
      if (expQ.size() == 0) begin
         errors++;
         $display("[TB] FAIL unexpected_output: got %h, no change expected", got);
      end else begin
         e = expQ.pop_front();
         if (got !== e.value) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", e.name, got, e.value);
         end
      end
   endtask

   initial begin
      logic [87:0] prev;
      prev = 'x;
      forever begin
         @(negedge clk);
         if ((observed !== prev) || probeReq) begin
            checkOutput(observed);
         end
         prev = observed;
      end
   end

   // Decisions land MOVE_PERIOD+1 = 5 edges after reset release or a commit.
   task automatic applyStimulus();
      reset         = 1'b0;
      pacX          = 6'd19;
      pacY          = 5'd1;
      collisionType = 4'd0;
      pillCounter   = 33'd0;
      wrdone        = 1'b0;
      probeReq      = 1'b0;
      pushExp("reset", cells(19, 14, 20, 14, 19, 14, 20, 14));
      tick(2);
      reset = 1'b1;
      tick(2);
      probe("hold_after_reset", cells(19, 14, 20, 14, 19, 14, 20, 14));
      pushExp("decide_normal", cells(19, 14, 20, 14, 19, 13, 19, 14));
      tick(9);
      probe("hold_without_wrdone", cells(19, 14, 20, 14, 19, 13, 19, 14));
      pushExp("commit", cells(19, 13, 19, 14, 19, 13, 19, 14));
      wrdone = 1'b1;
      tick(1);
      pillCounter = 33'd100;
      tick(1);
      wrdone = 1'b0;
      probe("second_wrdone_ignored", cells(19, 13, 19, 14, 19, 13, 19, 14));
      pushExp("decide_frightened", cells(19, 13, 19, 14, 18, 13, 18, 14));
      tick(5);
      reset = 1'b0;
      pushExp("reset_in_wait", cells(19, 14, 20, 14, 19, 14, 20, 14));
      tick(1);
      reset  = 1'b1;
      wrdone = 1'b1;
      tick(1);
      wrdone = 1'b0;
      probe("late_wrdone_ignored", cells(19, 14, 20, 14, 19, 14, 20, 14));
      pushExp("frightened_from_home", cells(19, 14, 20, 14, 19, 15, 21, 14));
      tick(4);
      pushExp("commit_frightened", cells(19, 15, 21, 14, 19, 15, 21, 14));
      wrdone        = 1'b1;
      collisionType = 4'd5;
      pillCounter   = 33'd0;
      tick(1);
      wrdone = 1'b0;
      tick(6);
      probe("freeze_on_catch", cells(19, 15, 21, 14, 19, 15, 21, 14));
      collisionType = 4'd0;
      pacX          = 6'd30;
      pacY          = 5'd20;
      pushExp("move_after_freeze", cells(19, 15, 21, 14, 19, 16, 22, 14));
      tick(4);
      probe("hold_final", cells(19, 15, 21, 14, 19, 16, 22, 14));
      tick(2);
   endtask

   initial begin
      exp_t e;
      applyStimulus();
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         checks++;
         errors++;
         $display("[TB] FAIL %s: got no output, expected %h", e.name, e.value);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
